// File: rtl/spi_txn_arbiter_if.sv
// Requester and SPI byte-master signals shared by spi_txn_arbiter.
// The slave modport is the arbiter's view; the master modport drives it.
interface spi_txn_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DLY_W   = 16
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*16-1:0]    req_addr;
    logic [NUM_REQ*16-1:0]    req_data;
    logic [NUM_REQ*DLY_W-1:0] req_delay;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;
    logic [7:0]               spi_tx_byte;
    logic                     spi_tx_dv;
    logic                     spi_tx_ready;

    modport slave (
        input  req_valid, req_addr, req_data, req_delay, spi_tx_ready,
        output req_ready, done, busy, spi_tx_byte, spi_tx_dv
    );

    modport master (
        output req_valid, req_addr, req_data, req_delay, spi_tx_ready,
        input  req_ready, done, busy, spi_tx_byte, spi_tx_dv
    );
endinterface

// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter that serializes 16-bit addr/data register writes
// as four bytes onto a single SPI byte master, with optional hold-off.
module spi_txn_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DLY_W   = 16
) (
    input logic clk40M,
    input logic rst,
    spi_txn_arbiter_if.slave bus
);
    localparam int GW = $clog2(NUM_REQ);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] DELAY = 2'd2;

    logic [1:0]       state;
    logic [GW-1:0]    last;
    logic [GW-1:0]    gnt;
    logic [GW-1:0]    winner;
    logic [GW-1:0]    pos;
    logic             winValid;
    logic             readyQ;
    logic             rdyEdge;
    logic [1:0]       idx;
    logic [15:0]      addrQ;
    logic [15:0]      dataQ;
    logic [DLY_W-1:0] dlyQ;
    logic [DLY_W-1:0] cnt;
    logic [7:0]       nextByte;

    logic [15:0]      addrArr [NUM_REQ];
    logic [15:0]      dataArr [NUM_REQ];
    logic [DLY_W-1:0] dlyArr  [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : gSlice
        assign addrArr[i] = bus.req_addr[16*i +: 16];
        assign dataArr[i] = bus.req_data[16*i +: 16];
        assign dlyArr[i]  = bus.req_delay[DLY_W*i +: DLY_W];
    end

    assign rdyEdge = bus.spi_tx_ready & ~readyQ;

    // Scan upward from last+1 with wrap; first valid hit wins.
    always_comb begin
        winner   = last;
        winValid = 1'b0;
        pos      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            pos = GW'((int'(last) + k) % NUM_REQ);
            if (!winValid && bus.req_valid[pos]) begin
                winValid = 1'b1;
                winner   = pos;
            end
        end
    end

    always_comb begin
        unique case (idx)
            2'd0:    nextByte = addrQ[15:8];
            2'd1:    nextByte = dataQ[7:0];
            default: nextByte = dataQ[15:8];
        endcase
    end

    always_ff @(posedge clk40M) begin
        if (rst) begin
            state           <= IDLE;
            last            <= GW'(NUM_REQ - 1);
            gnt             <= '0;
            readyQ          <= 1'b1;
            idx             <= '0;
            cnt             <= '0;
            addrQ           <= '0;
            dataQ           <= '0;
            dlyQ            <= '0;
            bus.req_ready   <= '0;
            bus.done        <= '0;
            bus.busy        <= 1'b0;
            bus.spi_tx_byte <= '0;
            bus.spi_tx_dv   <= 1'b0;
        end else begin
            readyQ        <= bus.spi_tx_ready;
            bus.req_ready <= '0;
            bus.done      <= '0;
            bus.spi_tx_dv <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (winValid && bus.spi_tx_ready) begin
                        gnt                   <= winner;
                        last                  <= winner;
                        addrQ                 <= addrArr[winner];
                        dataQ                 <= dataArr[winner];
                        dlyQ                  <= dlyArr[winner];
                        bus.req_ready[winner] <= 1'b1;
                        bus.spi_tx_dv         <= 1'b1;
                        bus.spi_tx_byte       <= addrArr[winner][7:0];
                        bus.busy              <= 1'b1;
                        idx                   <= '0;
                        state                 <= WAIT;
                    end
                end
                WAIT: begin
                    if (rdyEdge) begin
                        if (idx != 2'd3) begin
                            bus.spi_tx_dv   <= 1'b1;
                            bus.spi_tx_byte <= nextByte;
                            idx             <= idx + 2'd1;
                        end else if (dlyQ == '0) begin
                            bus.done[gnt] <= 1'b1;
                            bus.busy      <= 1'b0;
                            state         <= IDLE;
                        end else begin
                            cnt   <= dlyQ;
                            state <= DELAY;
                        end
                    end
                end
                DELAY: begin
                    cnt <= cnt - DLY_W'(1);
                    if (cnt == DLY_W'(1)) begin
                        bus.done[gnt] <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter with a behavioural SPI byte master
// (16 clocks per half-bit, so 256 clocks per byte).
module tb_spi_txn_arbiter;
    localparam int NREQ     = 2;
    localparam int DW       = 16;
    localparam int BYTE_CYC = 256;

    logic clk40M = 1'b0;
    logic rst    = 1'b1;
    logic holdOff = 1'b0;
    logic mdlReady = 1'b1;
    int   mdlCnt = 0;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int dvCnt = 0;
    int doneCnt = 0;
    int riseCyc = 0;
    logic prevDv = 1'b0;
    logic prevReady = 1'b1;
    logic [7:0] txBytes[$];

    spi_txn_arbiter_if #(.NUM_REQ(NREQ), .DLY_W(DW)) bus ();

    spi_txn_arbiter #(.NUM_REQ(NREQ), .DLY_W(DW)) dut (
        .clk40M(clk40M),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk40M = ~clk40M;
    always @(posedge clk40M) cyc <= cyc + 1;

    assign bus.spi_tx_ready = mdlReady & ~holdOff;

    // Byte master: ready drops after a strobe, returns once the byte is out.
    always @(posedge clk40M) begin
        if (bus.spi_tx_dv) begin
            mdlReady <= 1'b0;
            mdlCnt   <= BYTE_CYC;
        end else if (mdlCnt > 0) begin
            mdlCnt <= mdlCnt - 1;
            if (mdlCnt == 1) mdlReady <= 1'b1;
        end
    end

    always @(negedge clk40M) begin
        if (bus.spi_tx_dv) begin
            txBytes.push_back(bus.spi_tx_byte);
            dvCnt++;
            total++;
            assert (prevDv === 1'b0) else begin
                bad++;
                $error("FAIL dv_consecutive got=1 exp=0 cyc=%0d", cyc);
            end
        end
        if (bus.spi_tx_ready && !prevReady) riseCyc = cyc;
        if (|bus.done) doneCnt++;
        prevDv    = bus.spi_tx_dv;
        prevReady = bus.spi_tx_ready;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic waitGrant(input int maxCyc, output int who, output int at,
                             output logic dvNow);
        who = -1;
        at = -1;
        dvNow = 1'b0;
        for (int i = 0; i < maxCyc; i++) begin
            @(negedge clk40M);
            if (|bus.req_ready) begin
                at = cyc;
                dvNow = bus.spi_tx_dv;
                for (int j = 0; j < NREQ; j++)
                    if (bus.req_ready[j]) who = j;
                return;
            end
        end
    endtask

    task automatic waitDone(input int maxCyc, output int who, output int at,
                            output logic busyDrop, output logic busyAt);
        who = -1;
        at = -1;
        busyDrop = 1'b0;
        busyAt = 1'b1;
        for (int i = 0; i < maxCyc; i++) begin
            @(negedge clk40M);
            if (|bus.done) begin
                at = cyc;
                busyAt = bus.busy;
                for (int j = 0; j < NREQ; j++)
                    if (bus.done[j]) who = j;
                return;
            end
            if (!bus.busy) busyDrop = 1'b1;
        end
    endtask

    function automatic logic [31:0] packBytes();
        logic [31:0] v;
        v = '1;
        for (int i = 0; i < txBytes.size() && i < 4; i++)
            v[i*8 +: 8] = txBytes[i];
        return v;
    endfunction

    task automatic doReset();
        @(negedge clk40M);
        rst = 1'b1;
        repeat (2) @(negedge clk40M);
        rst = 1'b0;
    endtask

    initial begin
        int who, at, s, n, dc;
        logic dvNow, bDrop, bAt;

        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.req_delay = '0;

        repeat (3) @(negedge clk40M);
        check("rst_ready", 64'(bus.req_ready), 64'h0);
        check("rst_done", 64'(bus.done), 64'h0);
        check("rst_busy_dv", 64'({bus.busy, bus.spi_tx_dv}), 64'h0);
        check("rst_byte", 64'(bus.spi_tx_byte), 64'h0);
        rst = 1'b0;

        // single request, delay 0
        @(negedge clk40M);
        txBytes.delete();
        dvCnt = 0;
        bus.req_addr[15:0] = 16'h00F9;
        bus.req_data[15:0] = 16'hC007;
        bus.req_delay[15:0] = 16'd0;
        bus.req_valid = 2'b01;
        s = cyc;
        waitGrant(10, who, at, dvNow);
        check("t1_who", 64'(who), 64'd0);
        check("t1_lat", 64'(at - s), 64'd1);
        check("t1_dv_at_grant", 64'(dvNow), 64'd1);
        bus.req_valid = 2'b00;
        waitDone(2000, who, at, bDrop, bAt);
        check("t1_done_who", 64'(who), 64'd0);
        check("t1_done_lat", 64'(at - riseCyc), 64'd1);
        check("t1_busy_at_done", 64'(bAt), 64'd0);
        check("t1_nbytes", 64'(txBytes.size()), 64'd4);
        check("t1_bytes", 64'(packBytes()), 64'hC00700F9);
        check("t1_dvcnt", 64'(dvCnt), 64'd4);

        // fairness: both valid continuously
        doReset();
        bus.req_addr = {16'h3333, 16'h1111};
        bus.req_data = {16'h4444, 16'h2222};
        bus.req_delay = '0;
        bus.req_valid = 2'b11;
        dc = -1;
        for (int i = 0; i < 4; i++) begin
            waitGrant(10, who, at, dvNow);
            check($sformatf("t2_grant%0d", i), 64'(who), 64'(i % 2));
            if (i > 0) check($sformatf("t2_b2b%0d", i), 64'(at - dc), 64'd1);
            waitDone(2000, who, dc, bDrop, bAt);
            check($sformatf("t2_done%0d", i), 64'(who), 64'(i % 2));
            if (i == 3) bus.req_valid = 2'b00;
        end

        // post-transaction delay of 20
        @(negedge clk40M);
        txBytes.delete();
        bus.req_addr[15:0] = 16'hABCD;
        bus.req_data[15:0] = 16'h1234;
        bus.req_delay[15:0] = 16'd20;
        bus.req_valid = 2'b01;
        waitGrant(10, who, at, dvNow);
        check("t3_who", 64'(who), 64'd0);
        bus.req_valid = 2'b00;
        waitDone(2000, who, at, bDrop, bAt);
        check("t3_done_who", 64'(who), 64'd0);
        check("t3_done_lat", 64'(at - riseCyc), 64'd21);
        check("t3_busy_held", 64'(bDrop), 64'd0);
        check("t3_bytes", 64'(packBytes()), 64'h1234ABCD);
        bus.req_delay[15:0] = 16'd0;

        // master not ready
        @(negedge clk40M);
        holdOff = 1'b1;
        bus.req_addr[31:16] = 16'h5555;
        bus.req_data[31:16] = 16'h6666;
        bus.req_valid = 2'b10;
        waitGrant(10, who, at, dvNow);
        check("t4_no_grant", 64'(who), 64'hFFFF_FFFF_FFFF_FFFF);
        holdOff = 1'b0;
        s = cyc;
        waitGrant(10, who, at, dvNow);
        check("t4_who", 64'(who), 64'd1);
        check("t4_lat", 64'(at - s), 64'd1);
        check("t4_dv", 64'(dvNow), 64'd1);
        bus.req_valid = 2'b00;
        waitDone(2000, who, at, bDrop, bAt);
        check("t4_done_who", 64'(who), 64'd1);

        // reset after byte1 strobe
        @(negedge clk40M);
        bus.req_addr[15:0] = 16'h0102;
        bus.req_data[15:0] = 16'h0304;
        bus.req_valid = 2'b01;
        waitGrant(10, who, at, dvNow);
        bus.req_valid = 2'b00;
        n = 0;
        for (int i = 0; i < 1000 && n == 0; i++) begin
            @(negedge clk40M);
            if (bus.spi_tx_dv) n = 1;
        end
        check("t5_saw_byte1", 64'(n), 64'd1);
        rst = 1'b1;
        @(negedge clk40M);
        check("t5_rst_outs", 64'({bus.req_ready, bus.done, bus.busy,
              bus.spi_tx_dv, bus.spi_tx_byte}), 64'h0);
        rst = 1'b0;
        txBytes.delete();
        dc = doneCnt;
        bus.req_addr[31:16] = 16'h5A5A;
        bus.req_data[31:16] = 16'hA5A5;
        bus.req_valid = 2'b10;
        waitGrant(600, who, at, dvNow);
        check("t5_no_done", 64'(doneCnt - dc), 64'd0);
        check("t5_who", 64'(who), 64'd1);
        check("t5_after_ready", 64'(at - riseCyc), 64'd1);
        bus.req_valid = 2'b00;
        waitDone(2000, who, at, bDrop, bAt);
        check("t5_done_who", 64'(who), 64'd1);
        check("t5_bytes", 64'(packBytes()), 64'hA5A55A5A);

        // input change after grant
        @(negedge clk40M);
        txBytes.delete();
        bus.req_addr[15:0] = 16'h0A0B;
        bus.req_data[15:0] = 16'h0C0D;
        bus.req_valid = 2'b01;
        waitGrant(10, who, at, dvNow);
        bus.req_valid = 2'b00;
        bus.req_addr[15:0] = 16'hFFFF;
        bus.req_data[15:0] = 16'hEEEE;
        waitDone(2000, who, at, bDrop, bAt);
        check("t6_done_who", 64'(who), 64'd0);
        check("t6_bytes", 64'(packBytes()), 64'h0C0D0A0B);

        repeat (3) @(negedge clk40M);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
